// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int ST_BUSY_BIT   = 0;
    localparam int ST_OVF_BIT    = 1;
    localparam int ST_FULL_BIT   = 2;
    localparam int ST_COUNT_LSB  = 4;
    localparam int OVF_CLEAR_BIT = 1;

    localparam logic [31:0] DEFAULT_TX_ADDR     = 32'h0000_00F0;
    localparam logic [31:0] DEFAULT_STATUS_ADDR = 32'h0000_00F4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output; push and pop may coincide even when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A pop at the same edge frees the slot a full-FIFO push needs.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 serial transmitter fed from the core's store port via a small FIFO.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] TX_ADDR      = DEFAULT_TX_ADDR,
    parameter logic [31:0] STATUS_ADDR  = DEFAULT_STATUS_ADDR,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memWrite,
    input  logic [31:0] memDataAddr,
    input  logic [31:0] memWriteData,
    output logic [31:0] statusData,
    output logic        txd,
    output logic        txBusy,
    output logic        fifoFull
);

    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state;
    logic [BAUD_W-1:0] baud;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              overflow;

    logic              tx_push;
    logic              status_wr;
    logic              tx_pop;
    logic              drop;
    logic              baud_done;
    logic [7:0]        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              unused_wdata;

    assign tx_push   = memWrite && (memDataAddr == TX_ADDR);
    assign status_wr = memWrite && (memDataAddr == STATUS_ADDR);
    assign baud_done = (baud == BAUD_LAST);

    // The serialiser takes a new byte when idle or exactly at the end of a stop bit.
    assign tx_pop = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_done));
    assign drop   = tx_push && fifo_full && !tx_pop;

    assign unused_wdata = ^memWriteData[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (memWriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky overflow; a drop on the same edge as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (status_wr && memWriteData[OVF_CLEAR_BIT]) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    txd  <= 1'b1;
                    baud <= '0;
                    if (tx_pop) begin
                        shift <= fifo_dout;
                        state <= START;
                        txd   <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        txd     <= shift[0];
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            txd     <= shift[1];
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (tx_pop) begin
                            shift <= fifo_dout;
                            state <= START;
                            txd   <= 1'b0;
                        end else begin
                            state <= IDLE;
                            txd   <= 1'b1;
                        end
                    end else begin
                        baud <= baud + BAUD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

    assign txBusy   = (state != IDLE) || (fifo_count != '0);
    assign fifoFull = fifo_full;

    always_comb begin
        statusData                         = '0;
        statusData[ST_BUSY_BIT]            = txBusy;
        statusData[ST_OVF_BIT]             = overflow;
        statusData[ST_FULL_BIT]            = fifo_full;
        statusData[ST_COUNT_LSB +: CW]     = fifo_count;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboarded bench: expected bytes are queued at store time and matched by a serial-line receiver.
module tb_mmio_uart_tx;

    localparam int CPB = 4;
    localparam logic [31:0] TXA = 32'h0000_00F0;
    localparam logic [31:0] STA = 32'h0000_00F4;

    logic        clk;
    logic        reset;
    logic        memWrite;
    logic [31:0] memDataAddr;
    logic [31:0] memWriteData;
    logic [31:0] statusData;
    logic        txd;
    logic        txBusy;
    logic        fifoFull;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];
    logic       mon_en;
    logic [7:0] mon_rx;
    logic [7:0] mon_exp;
    int prev_start = 0;
    int last_gap = 0;

    mmio_uart_tx #(
        .TX_ADDR      (TXA),
        .STATUS_ADDR  (STA),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .memWrite     (memWrite),
        .memDataAddr  (memDataAddr),
        .memWriteData (memWriteData),
        .statusData   (statusData),
        .txd          (txd),
        .txBusy       (txBusy),
        .fifoFull     (fifoFull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the store is captured by the next posedge and the task returns one negedge later.
    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        memWrite     = 1'b1;
        memDataAddr  = addr;
        memWriteData = data;
        @(negedge clk);
        memWrite     = 1'b0;
        memDataAddr  = 32'h0;
        memWriteData = 32'h0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((txBusy || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("drain_busy", {31'b0, txBusy}, 32'd0);
        check("drain_sb_empty", exp_q.size(), 32'd0);
    endtask

    function automatic logic [31:0] fifo_cnt();
        return {29'b0, statusData[6:4]};
    endfunction

    // Serial receiver: detects the start bit on a negedge, then samples each bit mid-way.
    always begin
        @(negedge clk);
        if (mon_en && !reset && txd === 1'b0) begin
            last_gap   = cyc - prev_start;
            prev_start = cyc;
            repeat (CPB / 2) @(negedge clk);
            check("start_bit", {31'b0, txd}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mon_rx[i] = txd;
            end
            repeat (CPB) @(negedge clk);
            check("stop_bit", {31'b0, txd}, 32'd1);
            check("frame_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("rx_byte", {24'b0, mon_rx}, {24'b0, mon_exp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        memWrite     = 1'b0;
        memDataAddr  = 32'h0;
        memWriteData = 32'h0;
        mon_en       = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_txd", {31'b0, txd}, 32'd1);
        check("rst_status", statusData, 32'd0);
        check("rst_busy", {31'b0, txBusy}, 32'd0);
        check("rst_full", {31'b0, fifoFull}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single byte: fall one edge after capture, busy for exactly 40 cycles from the fall.
        exp_q.push_back(8'h55);
        store(TXA, 32'h0000_1255);
        check("t1_txd_before_fall", {31'b0, txd}, 32'd1);
        check("t1_busy_queued", {31'b0, txBusy}, 32'd1);
        @(negedge clk);
        check("t1_txd_fall", {31'b0, txd}, 32'd0);
        repeat (39) @(negedge clk);
        check("t1_busy_last_cycle", {31'b0, txBusy}, 32'd1);
        @(negedge clk);
        check("t1_busy_drop", {31'b0, txBusy}, 32'd0);
        wait_drain();

        // Back-to-back frames with no idle gap.
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        store(TXA, 32'h0000_00A5);
        store(TXA, 32'h0000_003C);
        wait_drain();
        check("b2b_gap", last_gap, 32'd40);

        // Overflow: 0x06 is dropped, then the flag is cleared by a status store.
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) exp_q.push_back(8'(i));
            store(TXA, 32'(i));
        end
        check("ovf_set", {31'b0, statusData[1]}, 32'd1);
        check("ovf_full", {31'b0, fifoFull}, 32'd1);
        check("ovf_count", fifo_cnt(), 32'd4);
        wait_drain();
        check("ovf_sticky", {31'b0, statusData[1]}, 32'd1);
        store(STA, 32'h0000_0002);
        check("ovf_clear", {31'b0, statusData[1]}, 32'd0);

        // Address filter.
        store(32'h0000_00F8, 32'h0000_0077);
        store(32'h00F0_00F0, 32'h0000_0077);
        repeat (5) @(negedge clk);
        check("flt_txd", {31'b0, txd}, 32'd1);
        check("flt_count", fifo_cnt(), 32'd0);
        check("flt_busy", {31'b0, txBusy}, 32'd0);

        // Push while full coinciding with the pop at the end of the first stop bit.
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            store(TXA, 32'h10 + 32'(i));
        end
        check("fp_full_before", {31'b0, fifoFull}, 32'd1);
        repeat (36) @(negedge clk);
        check("fp_count_before", fifo_cnt(), 32'd4);
        exp_q.push_back(8'h15);
        store(TXA, 32'h0000_0015);
        check("fp_ovf", {31'b0, statusData[1]}, 32'd0);
        check("fp_count_after", fifo_cnt(), 32'd4);
        check("fp_full_after", {31'b0, fifoFull}, 32'd1);
        wait_drain();

        // Reset during data bit 3 discards the frame and the queued byte.
        mon_en = 1'b0;
        store(TXA, 32'h0000_0000);
        store(TXA, 32'h0000_005A);
        repeat (16) @(negedge clk);
        check("mr_txd_low", {31'b0, txd}, 32'd0);
        #1 reset = 1'b1;
        #1;
        check("mr_txd_high", {31'b0, txd}, 32'd1);
        check("mr_status", statusData, 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        exp_q.push_back(8'h81);
        store(TXA, 32'h0000_0081);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
